port_rd_egress: RTL and testbench

PORT_RD_EGRESS -- requirements
Module: port_rd_egress

---
 rtl/port_rd_pkg.sv | 14 +
 rtl/port_rd_fifo.sv | 55 +++++
 rtl/port_rd_egress.sv | 152 +++++++++++++++
 tb/tb_port_rd_egress.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/port_rd_pkg.sv
// Shared types and default sizes for the read-port egress block.
// Optional feature: PORT_RD_STATS_EN adds egress packet/beat counters.
package port_rd_pkg;

    localparam int DEF_DW        = 16;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_MAX_BEATS = 512;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } trk_e;

endpackage

// File: rtl/port_rd_fifo.sv
// Synchronous FIFO with combinational head read, full/empty and count.
// Simultaneous push and pop are allowed in any non-degenerate state.
module port_rd_fifo #(
    parameter int W = 18,
    parameter int D = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(D+1)-1:0] count_o
);

    localparam int AW = $clog2(D);
    localparam int CW = $clog2(D+1);

    logic [W-1:0]  mem_q [D];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == CW'(D));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/port_rd_egress.sv
// Packet egress: SOP tagging, length check, skid FIFO, registered rd_* port.
// Optional feature: PORT_RD_STATS_EN adds pkt_cnt/beat_cnt outputs.
module port_rd_egress
    import port_rd_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          xfer_data_vld,
    input  logic [DW-1:0] xfer_data,
    input  logic          end_of_packet,
    output logic          xfer_rdy,
    output logic          rd_vld,
    output logic [DW-1:0] rd_data,
    output logic          rd_sop,
    output logic          rd_eop,
    input  logic          ready,
    output logic          ovf_err,
    output logic          len_err
`ifdef PORT_RD_STATS_EN
    ,
    output logic [31:0]   pkt_cnt,
    output logic [31:0]   beat_cnt
`endif
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int LW = $clog2(MAX_BEATS+1);
    localparam int FW = DW + 2;

    trk_e          trk_q;
    logic [LW-1:0] len_q;
    logic          ovf_q, lerr_q;
    logic          rd_vld_q, rd_vld_d;
    logic          rd_sop_q, rd_sop_d;
    logic          rd_eop_q, rd_eop_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic [CW-1:0] fcnt;
    logic [CW:0]   occ;
    logic [FW-1:0] fhead, beat;
    logic          ffull, fempty;
    logic          accept, pop_out, load;
    logic          fifo_push, fifo_pop, bypass;

    // Occupancy counts the output register so total buffering is DEPTH.
    assign occ      = {1'b0, fcnt} + {{CW{1'b0}}, rd_vld_q};
    assign xfer_rdy = ~rst & (occ < (CW+1)'(DEPTH));

    assign accept    = xfer_data_vld & xfer_rdy;
    assign beat      = {trk_q == IDLE, end_of_packet, xfer_data};
    assign pop_out   = rd_vld_q & ready;
    assign load      = ~rd_vld_q | pop_out;
    assign fifo_pop  = load & ~fempty;
    assign bypass    = load & fempty & accept;
    assign fifo_push = accept & ~bypass & ~ffull;

    port_rd_fifo #(.W(FW), .D(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (beat),
        .rdata_o (fhead),
        .full_o  (ffull),
        .empty_o (fempty),
        .count_o (fcnt)
    );

    always_comb begin
        rd_vld_d  = rd_vld_q;
        rd_sop_d  = rd_sop_q;
        rd_eop_d  = rd_eop_q;
        rd_data_d = rd_data_q;
        if (load) begin
            if (!fempty) begin
                rd_vld_d = 1'b1;
                {rd_sop_d, rd_eop_d, rd_data_d} = fhead;
            end else if (accept) begin
                rd_vld_d = 1'b1;
                {rd_sop_d, rd_eop_d, rd_data_d} = beat;
            end else begin
                rd_vld_d = 1'b0;
                rd_sop_d = 1'b0;
                rd_eop_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_sop_q  <= 1'b0;
            rd_eop_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q  <= rd_vld_d;
            rd_sop_q  <= rd_sop_d;
            rd_eop_q  <= rd_eop_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trk_q  <= IDLE;
            len_q  <= '0;
            ovf_q  <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            ovf_q  <= xfer_data_vld & ~xfer_rdy;
            lerr_q <= accept & ~end_of_packet & (len_q == LW'(MAX_BEATS));
            if (accept) begin
                if (end_of_packet) begin
                    trk_q <= IDLE;
                    len_q <= '0;
                end else begin
                    trk_q <= IN_PKT;
                    if (len_q != LW'(MAX_BEATS)) len_q <= len_q + 1'b1;
                end
            end
        end
    end

    assign rd_vld  = rd_vld_q;
    assign rd_sop  = rd_sop_q;
    assign rd_eop  = rd_eop_q;
    assign rd_data = rd_data_q;
    assign ovf_err = ovf_q;
    assign len_err = lerr_q;

`ifdef PORT_RD_STATS_EN
    logic [31:0] pkt_cnt_q, beat_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else if (pop_out) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
            if (rd_eop_q) pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_port_rd_egress.sv
// Randomized and directed bench for port_rd_egress against a queue model.
// Define PORT_RD_STATS_EN to also check the stats counters.
module tb_port_rd_egress;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int MAXB  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          xfer_data_vld;
    logic [DW-1:0] xfer_data;
    logic          end_of_packet;
    logic          xfer_rdy;
    logic          rd_vld;
    logic [DW-1:0] rd_data;
    logic          rd_sop;
    logic          rd_eop;
    logic          ready;
    logic          ovf_err;
    logic          len_err;
`ifdef PORT_RD_STATS_EN
    logic [31:0]   pkt_cnt;
    logic [31:0]   beat_cnt;
`endif

    always #5 clk = ~clk;

    port_rd_egress #(.DW(DW), .DEPTH(DEPTH), .MAX_BEATS(MAXB)) dut (
        .clk           (clk),
        .rst           (rst),
        .xfer_data_vld (xfer_data_vld),
        .xfer_data     (xfer_data),
        .end_of_packet (end_of_packet),
        .xfer_rdy      (xfer_rdy),
        .rd_vld        (rd_vld),
        .rd_data       (rd_data),
        .rd_sop        (rd_sop),
        .rd_eop        (rd_eop),
        .ready         (ready),
        .ovf_err       (ovf_err),
        .len_err       (len_err)
`ifdef PORT_RD_STATS_EN
        ,
        .pkt_cnt       (pkt_cnt),
        .beat_cnt      (beat_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: beats buffered inside the block, in egress order.
    logic [DW+1:0] q [$];
    int   pk_beats;
    logic exp_ovf, exp_len;
    int   m_pkts, m_beats;
    int   n_ovf_seen, n_len_seen;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_outputs();
        chk("xfer_rdy", xfer_rdy, q.size() < DEPTH);
        chk("rd_vld", rd_vld, q.size() > 0);
        if (q.size() > 0) begin
            chk("rd_data", rd_data, q[0][DW-1:0]);
            chk("rd_sop", rd_sop, q[0][DW+1]);
            chk("rd_eop", rd_eop, q[0][DW]);
        end else begin
            chk("idle_sop", rd_sop, 1'b0);
            chk("idle_eop", rd_eop, 1'b0);
        end
        chk("ovf_err", ovf_err, exp_ovf);
        chk("len_err", len_err, exp_len);
        if (ovf_err) n_ovf_seen++;
        if (len_err) n_len_seen++;
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic e, input logic r);
        logic acc, pop, n_ovf, n_len;
        xfer_data_vld = v;
        xfer_data     = d;
        end_of_packet = e;
        ready         = r;
        acc   = v && (q.size() < DEPTH);
        pop   = (q.size() > 0) && r;
        n_ovf = v && !(q.size() < DEPTH);
        n_len = acc && !e && (pk_beats >= MAXB);
        if (pop) begin
            m_beats++;
            if (q[0][DW]) m_pkts++;
            void'(q.pop_front());
        end
        if (acc) begin
            q.push_back({pk_beats == 0, e, d});
            pk_beats = e ? 0 : pk_beats + 1;
        end
        @(posedge clk);
        @(negedge clk);
        exp_ovf = n_ovf;
        exp_len = n_len;
        check_outputs();
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        xfer_data_vld = 1'b0;
        ready         = 1'b0;
        end_of_packet = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_xfer_rdy", xfer_rdy, 1'b0);
        chk("rst_rd_vld", rd_vld, 1'b0);
        chk("rst_rd_sop", rd_sop, 1'b0);
        chk("rst_rd_eop", rd_eop, 1'b0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_ovf", ovf_err, 1'b0);
        chk("rst_len", len_err, 1'b0);
`ifdef PORT_RD_STATS_EN
        chk("rst_pkt_cnt", pkt_cnt, 32'd0);
        chk("rst_beat_cnt", beat_cnt, 32'd0);
`endif
        rst = 1'b0;
        q.delete();
        pk_beats = 0;
        exp_ovf  = 1'b0;
        exp_len  = 1'b0;
        m_pkts   = 0;
        m_beats  = 0;
        #1;
        chk("rel_xfer_rdy", xfer_rdy, 1'b1);
    endtask

    initial begin
        xfer_data = '0;
        do_reset();

        // 3-beat packet, ready high: 0x11 sop, 0x33 eop.
        step(1, 16'h0011, 0, 1);
        chk("p3_first_vld", rd_vld, 1'b1);
        chk("p3_first_sop", rd_sop, 1'b1);
        step(1, 16'h0022, 0, 1);
        step(1, 16'h0033, 1, 1);
        chk("p3_last_eop", rd_eop, 1'b1);
        step(0, 16'h0000, 0, 1);

        // Single-beat packet then the next packet's first beat.
        step(1, 16'h00AB, 1, 1);
        chk("single_sop", rd_sop, 1'b1);
        chk("single_eop", rd_eop, 1'b1);
        step(1, 16'h00CD, 0, 1);
        chk("after_single_sop", rd_sop, 1'b1);
        step(1, 16'h00CE, 1, 1);
        step(0, 16'h0000, 0, 1);

        // Backpressure: 6 offered with ready low, 4 kept, 2 overflow.
        n_ovf_seen = 0;
        for (int i = 0; i < 6; i++)
            step(1, 16'h00A0 + 16'(i), i == 5, 0);
        step(0, 16'h0000, 0, 0);
        chk("ovf_pulses", n_ovf_seen, 2);
        chk("full_rdy_low", xfer_rdy, 1'b0);
        for (int i = 0; i < 5; i++) step(0, 16'h0000, 0, 1);
        chk("drained_rdy", xfer_rdy, 1'b1);
        do_reset();

        // 6-beat packet with MAX_BEATS = 4: len_err on beat 5 only.
        n_len_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 16'h0060 + 16'(i), i == 5, 1);
            if (i == 4) chk("len_beat5", len_err, 1'b1);
        end
        step(0, 16'h0000, 0, 1);
        chk("len_pulses", n_len_seen, 1);

        // Reset in the middle of a packet.
        step(1, 16'h0041, 0, 0);
        step(1, 16'h0042, 0, 0);
        do_reset();
        step(1, 16'h0055, 1, 1);
        chk("post_rst_sop", rd_sop, 1'b1);
        chk("post_rst_data", rd_data, 16'h0055);
        step(0, 16'h0000, 0, 1);

`ifdef PORT_RD_STATS_EN
        do_reset();
        for (int p = 0; p < 3; p++) begin
            step(1, 16'h0070 + 16'(p), 0, 1);
            step(1, 16'h0080 + 16'(p), 1, 1);
        end
        step(0, 16'h0000, 0, 1);
        chk("pkt_cnt3", pkt_cnt, 32'd3);
        chk("beat_cnt6", beat_cnt, 32'd6);
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            step($urandom_range(3, 0) != 0, 16'($urandom),
                 $urandom_range(3, 0) == 0, $urandom_range(9, 0) < 7);
        for (int i = 0; i < 8; i++) step(0, 16'h0000, 0, 1);
        chk("final_empty", rd_vld, 1'b0);
`ifdef PORT_RD_STATS_EN
        chk("rand_pkt_cnt", pkt_cnt, 32'(m_pkts));
        chk("rand_beat_cnt", beat_cnt, 32'(m_beats));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
